uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte producers.
- Sits directly in front of the UART TX top. Selects a requester, presents its byte and frame config (parity enable/type) with a one-cycle data_valid pulse, then tracks the transmitter's registered busy flag to frame completion.
- Returns per-requester grant and done pulses.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, cycles allowed between issue and tx_busy rising (watchdog only).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request; held high until grant
- req_data  input  8*NUM_REQ  byte for requester i at [8i+7:8i]
- req_par_en  input  NUM_REQ  parity enable per requester
- req_par_typ  input  NUM_REQ  parity type per requester (0 even, 1 odd)
- grant  output  NUM_REQ  one-hot, 1-cycle pulse; byte accepted
- done  output  NUM_REQ  one-hot, 1-cycle pulse; frame fully sent
- tx_p_data  output  8  byte to transmitter
- tx_data_valid  output  1  1-cycle load strobe to transmitter
- tx_par_en  output  1  parity enable to transmitter
- tx_par_typ  output  1  parity type to transmitter
- tx_busy  input  1  registered busy from transmitter
- arb_busy  output  1  high in any state other than IDLE
- err  output  1  1-cycle pulse on watchdog expiry (0 if feature off)

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = 0; watchdog counter = 0. Reset mid-frame aborts tracking immediately. No done is issued for the aborted frame; the transmitter is reset by the same rst.
- All outputs are registered.
- IDLE:
  - If |req and !tx_busy: winner = first set req at or after the rr pointer, searching upward with wrap at NUM_REQ-1 -> 0.
  - Latch winner index, req_data slice, req_par_en and req_par_typ into tx_p_data, tx_par_en and tx_par_typ. Go to ISSUE.
  - If tx_busy is high (external use or stale), stay in IDLE.
- ISSUE (1 cycle): tx_data_valid=1, grant[winner]=1. Next state is WAIT_BUSY.
- tx_p_data, tx_par_en and tx_par_typ hold from ISSUE until the next ISSUE. This is stable for the transmitter's parity/serialiser latch.
- WAIT_BUSY:
  - Wait for tx_busy=1, which covers the transmitter's register latency of ≥1 cycle. On tx_busy=1 -> WAIT_DONE.
- WAIT_DONE:
  - On tx_busy=0: done[winner]=1 for 1 cycle, rr pointer = winner+1 (wraps to 0 after NUM_REQ-1), -> IDLE.
- Minimum gap: one IDLE cycle between done and the next tx_data_valid. Back-to-back frames are therefore separated by ≥1 idle bit-clock, which is acceptable.
- req deasserted before grant: withdrawn, not served, no done.
- req is sampled only in IDLE. Changes during a frame do not affect the current transfer.
- Simultaneous requests: exactly one grant. The fairness bound is that each requester is served within NUM_REQ frames.
- grant and done are never asserted together. No output changes in the cycle after reset release except via IDLE evaluation.

Optional Feature:
- Macro: UART_TX_ARB_WDOG_EN.
- Defined:
  - Counter clears on entry to WAIT_BUSY and increments each cycle there.
  - If it reaches BUSY_TIMEOUT-1 with tx_busy still 0: err=1 for 1 cycle, rr pointer = winner+1, -> IDLE, no done.
- Not defined: no counter; WAIT_BUSY waits indefinitely; err tied to 0.

Decomposition:
- Package uart_tx_arb_pkg:
  - State enum: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE (2-bit).
  - Index-width function (clog2 of NUM_REQ).
  - Parity-type constants PAR_EVEN=0, PAR_ODD=1.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req vector and pointer; outputs are winner index and valid. It is natural to separate out and is unit-testable.

Test Plan:
- Single request: req=4'b0010, data[15:8]=8'hA5, par_en=1, typ=1 -> next cycle grant=4'b0010 with tx_data_valid=1, tx_p_data=A5, tx_par_en=1, tx_par_typ=1. After tx_busy 1->0, done=4'b0010; arb_busy returns to 0.
- All four requesting continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0. Each tx_data_valid occurs only after the previous done plus 1 idle cycle.
- Requests 0 and 2 with pointer at 1 -> requester 2 wins first, then 0. The pointer wraps correctly from 3 to 0.
- tx_busy held high externally while req=4'b0001 -> no grant until tx_busy drops. Then grant on the second cycle after the drop.
- Reset asserted during WAIT_DONE -> next cycle all outputs 0 and state IDLE. No done for the aborted frame. Pointer = 0.
- With UART_TX_ARB_WDOG_EN and BUSY_TIMEOUT=16, tx_busy stuck 0 after issue -> err pulse 16 cycles after entering WAIT_BUSY, no done, and the next requester is served.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX round-robin arbiter.
// Optional watchdog is enabled by defining UART_TX_ARB_WDOG_EN.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!valid && req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ producers.
// Define UART_TX_ARB_WDOG_EN to enable the tx_busy watchdog and err pulse.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_par_en,
    input  logic [NUM_REQ-1:0]     req_par_typ,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             tx_p_data,
    output logic                   tx_data_valid,
    output logic                   tx_par_en,
    output logic                   tx_par_typ,
    input  logic                   tx_busy,
    output logic                   arb_busy,
    output logic                   err
);

    localparam int unsigned IW = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 2) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick;
    logic          pick_valid;
    logic [IW-1:0] ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    assign ptr_next = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);

`ifdef UART_TX_ARB_WDOG_EN
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0] wdog;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            winner        <= '0;
            grant         <= '0;
            done          <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= 1'b0;
            arb_busy      <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
            wdog          <= '0;
            err           <= 1'b0;
`endif
        end else begin
            grant         <= '0;
            done          <= '0;
            tx_data_valid <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
            err           <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // tx_busy high here means the line is in use elsewhere; hold off.
                    if (pick_valid && !tx_busy) begin
                        winner        <= pick;
                        tx_p_data     <= req_data[{pick, 3'b000} +: 8];
                        tx_par_en     <= req_par_en[pick];
                        tx_par_typ    <= req_par_typ[pick];
                        grant         <= NUM_REQ'(1) << pick;
                        tx_data_valid <= 1'b1;
                        arb_busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef UART_TX_ARB_WDOG_EN
                    wdog  <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_TX_ARB_WDOG_EN
                    else if (wdog == CW'(BUSY_TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        ptr      <= ptr_next;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done     <= NUM_REQ'(1) << winner;
                        ptr      <= ptr_next;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
